midi_note_tracker: RTL

// - Upstream feeder of the waveform combiner. Consumes raw MIDI bytes from the UART receiver and tracks held notes.
// - Keeps a table of up to NUM_SLOTS-FIRST_SLOT voice slots, each holding {note, velocity}.
// - On every table change, presents the whole table with an on-array and a one-cycle change strobe.

---
 rtl/midi_note_tracker.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/midi_note_tracker.sv
// MIDI byte parser and voice-slot table feeding the waveform combiner.
// Define VOICE_STEAL_EN to replace the oldest voice when a new note hits a full table.
module midi_note_tracker #(
    parameter int NUM_SLOTS  = 5,
    parameter int FIRST_SLOT = 1,
    parameter int CHANNEL    = 0
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [7:0]                  midi_byte_in,
    input  logic                        midi_byte_valid_in,
    output logic [NUM_SLOTS-1:0]        on_array_out,
    output logic [NUM_SLOTS-1:0][15:0]  midi_burst_data_out,
    output logic                        midi_burst_change_out,
    output logic                        slots_full_out
);

    localparam int IDXW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2
    } parse_state_e;

    parse_state_e state_q, state_d;
    logic [7:0]   status_q, status_d;
    logic [7:0]   d1_q, d1_d;
    logic [7:0]   d2_q, d2_d;
    logic         upd_q, upd_d;

    logic [NUM_SLOTS-1:0]       on_q, on_d;
    logic [NUM_SLOTS-1:0][7:0]  note_q, note_d;
    logic [NUM_SLOTS-1:0][7:0]  vel_q, vel_d;
    logic [NUM_SLOTS-1:0][2:0]  age_q, age_d;
    logic                       chg_pend_q, chg_pend_d;

    logic [NUM_SLOTS-1:0]       on_array_q, on_array_d;
    logic [NUM_SLOTS-1:0][15:0] data_out_q, data_out_d;
    logic                       change_q, change_d;
    logic                       full_q, full_d;

    logic            hit_s, free_found_s, alloc_s, ch_ok_s;
    logic [IDXW-1:0] hit_idx_s, free_idx_s, old_idx_s, alloc_idx_s;
    logic [2:0]      old_age_s;

    // Byte classifier and parser next-state logic
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        upd_d    = 1'b0;
        if (midi_byte_valid_in) begin
            if (midi_byte_in[7:3] == 5'b11111) begin
                state_d = state_q;
            end else if (midi_byte_in[7:4] == 4'hF) begin
                status_d = 8'h00;
                state_d  = WAIT_STATUS;
            end else if (midi_byte_in[7]) begin
                status_d = midi_byte_in;
                state_d  = WAIT_D1;
            end else begin
                case (state_q)
                    WAIT_STATUS: state_d = WAIT_STATUS;
                    WAIT_D1: begin
                        d1_d = midi_byte_in;
                        // Program change carries one data byte and never updates the table
                        if (status_q[7:4] == 4'hC) begin
                            state_d = WAIT_D1;
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        d2_d    = midi_byte_in;
                        upd_d   = 1'b1;
                        state_d = WAIT_D1;
                    end
                    default: state_d = WAIT_STATUS;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Parser registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= WAIT_STATUS;
            status_q <= 8'h00;
            d1_q     <= 8'h00;
            d2_q     <= 8'h00;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            upd_q    <= upd_d;
        end
    end

    // Slot search: matching note, lowest free slot and oldest occupied slot
    always_comb begin
        hit_s        = 1'b0;
        hit_idx_s    = IDXW'(FIRST_SLOT);
        free_found_s = 1'b0;
        free_idx_s   = IDXW'(FIRST_SLOT);
        old_idx_s    = IDXW'(FIRST_SLOT);
        old_age_s    = age_q[FIRST_SLOT];
        for (int i = FIRST_SLOT; i < NUM_SLOTS; i++) begin
            hit_idx_s    = (!hit_s && on_q[i] && (note_q[i] == d1_q)) ? IDXW'(i) : hit_idx_s;
            hit_s        = hit_s | (on_q[i] && (note_q[i] == d1_q));
            free_idx_s   = (!free_found_s && !on_q[i]) ? IDXW'(i) : free_idx_s;
            free_found_s = free_found_s | !on_q[i];
            // Strict compare keeps the lowest index on equal ages
            old_idx_s    = (age_q[i] > old_age_s) ? IDXW'(i) : old_idx_s;
            old_age_s    = (age_q[i] > old_age_s) ? age_q[i] : old_age_s;
        end
    end

    // Table update in the cycle after the second data byte
    always_comb begin
        on_d        = on_q;
        note_d      = note_q;
        vel_d       = vel_q;
        age_d       = age_q;
        alloc_s     = 1'b0;
        alloc_idx_s = free_idx_s;
        ch_ok_s     = (status_q[3:0] == 4'(CHANNEL));
        if (upd_q && ch_ok_s) begin
            case (status_q[7:4])
                4'h8, 4'h9: begin
                    if ((status_q[7:4] == 4'h9) && (d2_q != 8'h00)) begin
                        if (hit_s) begin
                            vel_d[hit_idx_s] = d2_q;
                        end else if (free_found_s) begin
                            alloc_s     = 1'b1;
                            alloc_idx_s = free_idx_s;
                        end else begin
`ifdef VOICE_STEAL_EN
                            alloc_s     = 1'b1;
                            alloc_idx_s = old_idx_s;
`else
                            alloc_s     = 1'b0;
`endif
                        end
                    end else if (hit_s) begin
                        on_d[hit_idx_s]   = 1'b0;
                        note_d[hit_idx_s] = 8'h00;
                        vel_d[hit_idx_s]  = 8'h00;
                        age_d[hit_idx_s]  = 3'd0;
                    end else begin
                        on_d = on_q;
                    end
                end
                4'hB: begin
                    if (d1_q == 8'h7B) begin
                        on_d   = '0;
                        note_d = '0;
                        vel_d  = '0;
                        age_d  = '0;
                    end else begin
                        on_d = on_q;
                    end
                end
                default: on_d = on_q;
            endcase
        end else begin
            on_d = on_q;
        end
        if (alloc_s) begin
            for (int j = FIRST_SLOT; j < NUM_SLOTS; j++) begin
                if (IDXW'(j) == alloc_idx_s) begin
                    on_d[j]   = 1'b1;
                    note_d[j] = d1_q;
                    vel_d[j]  = d2_q;
                    age_d[j]  = 3'd0;
                end else if (on_q[j]) begin
                    age_d[j] = (age_q[j] == 3'd7) ? 3'd7 : (age_q[j] + 3'd1);
                end else begin
                    age_d[j] = age_q[j];
                end
            end
        end else begin
            age_d = age_d;
        end
        chg_pend_d = (on_d != on_q) || (note_d != note_q) || (vel_d != vel_q);
    end

    // Voice table registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            on_q       <= '0;
            note_q     <= '0;
            vel_q      <= '0;
            age_q      <= '0;
            chg_pend_q <= 1'b0;
        end else begin
            on_q       <= on_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            age_q      <= age_d;
            chg_pend_q <= chg_pend_d;
        end
    end

    // Output snapshot, refreshed only when the table changed
    always_comb begin
        on_array_d = on_array_q;
        data_out_d = data_out_q;
        full_d     = full_q;
        change_d   = chg_pend_q;
        if (chg_pend_q) begin
            on_array_d = on_q;
            full_d     = &on_q[NUM_SLOTS-1:FIRST_SLOT];
            for (int i = 0; i < NUM_SLOTS; i++) begin
                data_out_d[i] = {note_q[i], vel_q[i]};
            end
        end else begin
            full_d = full_q;
        end
    end

    // Output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            on_array_q <= '0;
            data_out_q <= '0;
            change_q   <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            on_array_q <= on_array_d;
            data_out_q <= data_out_d;
            change_q   <= change_d;
            full_q     <= full_d;
        end
    end

    assign on_array_out          = on_array_q;
    assign midi_burst_data_out   = data_out_q;
    assign midi_burst_change_out = change_q;
    assign slots_full_out        = full_q;

endmodule
